// File: rtl/zoom_config_if.sv
// ============================================================================
// Module   : zoom_config_if
// Brief    : Button, algorithm and committed-configuration bundle between the
//            user-facing side and zoom_config_controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface zoom_config_if #(
  parameter int W_BITS     = 11,
  parameter int H_BITS     = 10,
  parameter int SHIFT_BITS = 2
);
  logic                  ZOOM_IN_BTN;
  logic                  ZOOM_OUT_BTN;
  logic [1:0]            ALGORITHM;
  logic                  ENGINE_IDLE;
  logic [SHIFT_BITS-1:0] SHIFT_FACTOR;
  logic                  SCALE_DIR;
  logic [W_BITS-1:0]     IMG_WIDTH_OUT;
  logic [H_BITS-1:0]     IMG_HEIGHT_OUT;
  logic                  CFG_UPDATE;
  logic                  CFG_PENDING;

  modport master (
    output ZOOM_IN_BTN, ZOOM_OUT_BTN, ALGORITHM, ENGINE_IDLE,
    input  SHIFT_FACTOR, SCALE_DIR, IMG_WIDTH_OUT, IMG_HEIGHT_OUT,
           CFG_UPDATE, CFG_PENDING
  );

  modport slave (
    input  ZOOM_IN_BTN, ZOOM_OUT_BTN, ALGORITHM, ENGINE_IDLE,
    output SHIFT_FACTOR, SCALE_DIR, IMG_WIDTH_OUT, IMG_HEIGHT_OUT,
           CFG_UPDATE, CFG_PENDING
  );
endinterface

`default_nettype wire

// File: rtl/zoom_config_controller.sv
// ============================================================================
// Module   : zoom_config_controller
// Brief    : Debounces zoom buttons, tracks the requested scale level per
//            algorithm class and commits it at an engine-idle boundary.
// Revision : 1.0
// ============================================================================
`default_nettype none

module zoom_config_controller #(
  parameter int IMG_WIDTH_IN    = 160,
  parameter int IMG_HEIGHT_IN   = 120,
  parameter int W_BITS          = 11,
  parameter int H_BITS          = 10,
  parameter int MAX_UP_SHIFT    = 3,
  parameter int MAX_DOWN_SHIFT  = 2,
  parameter int SHIFT_BITS      = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  wire logic      CLK,
  input  wire logic      RESET_N,
  zoom_config_if.slave   bus
);

  localparam int                    c_CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0]    c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [W_BITS-1:0]     c_W_IN     = W_BITS'(IMG_WIDTH_IN);
  localparam logic [H_BITS-1:0]     c_H_IN     = H_BITS'(IMG_HEIGHT_IN);
  localparam logic [SHIFT_BITS-1:0] c_UP_LIM   = SHIFT_BITS'(MAX_UP_SHIFT);
  localparam logic [SHIFT_BITS-1:0] c_DOWN_LIM = SHIFT_BITS'(MAX_DOWN_SHIFT);

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_WAIT_IDLE = 1'b1
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_evt;   // bit 0 zoom-in, bit 1 zoom-out

  assign w_raw = {bus.ZOOM_OUT_BTN, bus.ZOOM_IN_BTN};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic [1:0]         r_sync;
      logic               r_deb;
      logic [c_CNT_W-1:0] r_cnt;
      logic               r_evt;

      // Counter tracks consecutive cycles the synchronised level disagrees with the accepted one.
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          r_sync <= '0;
          r_deb  <= 1'b0;
          r_cnt  <= '0;
          r_evt  <= 1'b0;
        end else begin
          r_sync <= {r_sync[0], w_raw[gi]};
          r_evt  <= 1'b0;
          if (r_sync[1] != r_deb) begin
            if (r_cnt == c_CNT_LAST) begin
              r_deb <= r_sync[1];
              r_cnt <= '0;
              r_evt <= r_sync[1];
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt <= '0;
          end
        end
      end

      assign w_evt[gi] = r_evt;
    end
  endgenerate

  logic [1:0]            r_alg;
  logic [SHIFT_BITS-1:0] r_req_lvl;
  logic                  r_req_dir;
  logic [SHIFT_BITS-1:0] w_limit;

  assign w_limit = r_req_dir ? c_DOWN_LIM : c_UP_LIM;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_alg     <= 2'b00;
      r_req_lvl <= '0;
      r_req_dir <= 1'b0;
    end else begin
      r_alg <= bus.ALGORITHM;
      if (bus.ALGORITHM != r_alg) begin
        r_req_lvl <= SHIFT_BITS'(1);
        r_req_dir <= bus.ALGORITHM[1];
      end else if (w_evt == 2'b01 && r_req_lvl < w_limit) begin
        r_req_lvl <= r_req_lvl + 1'b1;
      end else if (w_evt == 2'b10 && r_req_lvl != '0) begin
        r_req_lvl <= r_req_lvl - 1'b1;
      end
    end
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_commit;
  logic                  w_differs;
  logic [SHIFT_BITS-1:0] r_shift;
  logic                  r_dir;
  logic [W_BITS-1:0]     r_width;
  logic [H_BITS-1:0]     r_height;
  logic                  r_upd;
  logic [W_BITS-1:0]     w_width_nxt;
  logic [H_BITS-1:0]     w_height_nxt;

  assign w_differs = ({r_req_dir, r_req_lvl} != {r_dir, r_shift});

  always_comb begin
    w_state_nxt  = r_state;
    w_commit     = 1'b0;
    w_width_nxt  = r_req_dir ? (c_W_IN >> r_req_lvl) : (c_W_IN << r_req_lvl);
    w_height_nxt = r_req_dir ? (c_H_IN >> r_req_lvl) : (c_H_IN << r_req_lvl);
    case (r_state)
      S_IDLE: begin
        if (w_differs) w_state_nxt = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (!w_differs) begin
          w_state_nxt = S_IDLE;
        end else if (bus.ENGINE_IDLE) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_dir    <= 1'b0;
      r_width  <= c_W_IN;
      r_height <= c_H_IN;
      r_upd    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_upd   <= w_commit;
      if (w_commit) begin
        r_shift  <= r_req_lvl;
        r_dir    <= r_req_dir;
        r_width  <= w_width_nxt;
        r_height <= w_height_nxt;
      end
    end
  end

  assign bus.SHIFT_FACTOR   = r_shift;
  assign bus.SCALE_DIR      = r_dir;
  assign bus.IMG_WIDTH_OUT  = r_width;
  assign bus.IMG_HEIGHT_OUT = r_height;
  assign bus.CFG_UPDATE     = r_upd;
  assign bus.CFG_PENDING    = (r_state == S_WAIT_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_zoom_config_controller.sv
// ============================================================================
// Module   : tb_zoom_config_controller
// Brief    : Directed and random stimulus against a cycle-level behavioural
//            model of the zoom configuration controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_zoom_config_controller;

  localparam int D    = 4;
  localparam int W_IN = 160;
  localparam int H_IN = 120;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  zoom_config_if #(.W_BITS(11), .H_BITS(10), .SHIFT_BITS(2)) bus ();

  zoom_config_controller #(
    .IMG_WIDTH_IN    (W_IN),
    .IMG_HEIGHT_IN   (H_IN),
    .W_BITS          (11),
    .H_BITS          (10),
    .MAX_UP_SHIFT    (3),
    .MAX_DOWN_SHIFT  (2),
    .SHIFT_BITS      (2),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;

  // Model state: synchroniser taps, accepted level, run length, event per button
  int m_s0[2], m_s1[2], m_deb[2], m_run[2], m_evt[2];
  int m_alg, m_lvl, m_dir, m_pend, m_upd;
  int c_lvl, c_dir, c_w, c_h;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int b = 0; b < 2; b++) begin
      m_s0[b] = 0; m_s1[b] = 0; m_deb[b] = 0; m_run[b] = 0; m_evt[b] = 0;
    end
    m_alg = 0; m_lvl = 0; m_dir = 0; m_pend = 0; m_upd = 0;
    c_lvl = 0; c_dir = 0; c_w = W_IN; c_h = H_IN;
  endtask

  task automatic step_model();
    int old_lvl, old_dir, lim, differs, alg, ei;
    int raw[2];
    old_lvl = m_lvl;
    old_dir = m_dir;
    alg     = int'(bus.ALGORITHM);
    ei      = int'(bus.ENGINE_IDLE);
    raw[0]  = int'(bus.ZOOM_IN_BTN);
    raw[1]  = int'(bus.ZOOM_OUT_BTN);

    lim = m_dir ? 2 : 3;
    if (alg != m_alg) begin
      m_lvl = 1;
      m_dir = alg / 2;
    end else if (m_evt[0] == 1 && m_evt[1] == 0) begin
      m_lvl = (m_lvl + 1 > lim) ? lim : m_lvl + 1;
    end else if (m_evt[1] == 1 && m_evt[0] == 0) begin
      m_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;
    end
    m_alg = alg;

    for (int b = 0; b < 2; b++) begin
      int ev;
      ev = 0;
      if (m_s1[b] != m_deb[b]) begin
        m_run[b]++;
        if (m_run[b] >= D) begin
          m_deb[b] = m_s1[b];
          m_run[b] = 0;
          ev = m_deb[b];
        end
      end else begin
        m_run[b] = 0;
      end
      m_evt[b] = ev;
      m_s1[b]  = m_s0[b];
      m_s0[b]  = raw[b];
    end

    m_upd   = 0;
    differs = (old_dir != c_dir) || (old_lvl != c_lvl);
    if (m_pend == 0) begin
      m_pend = differs;
    end else if (!differs) begin
      m_pend = 0;
    end else if (ei == 1) begin
      c_dir  = old_dir;
      c_lvl  = old_lvl;
      c_w    = old_dir ? W_IN / (1 << old_lvl) : W_IN * (1 << old_lvl);
      c_h    = old_dir ? H_IN / (1 << old_lvl) : H_IN * (1 << old_lvl);
      m_upd  = 1;
      m_pend = 0;
    end
  endtask

  initial begin
    reset_model();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) reset_model();
      else        step_model();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("shift",   int'(bus.SHIFT_FACTOR),   c_lvl);
      check("dir",     int'(bus.SCALE_DIR),      c_dir);
      check("width",   int'(bus.IMG_WIDTH_OUT),  c_w);
      check("height",  int'(bus.IMG_HEIGHT_OUT), c_h);
      check("update",  int'(bus.CFG_UPDATE),     m_upd);
      check("pending", int'(bus.CFG_PENDING),    m_pend);
      if (bus.CFG_UPDATE) upd_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 zoom-in, 1 zoom-out, 2 both together
  task automatic press(input int which, input int hold);
    bus.ZOOM_IN_BTN  = (which != 1);
    bus.ZOOM_OUT_BTN = (which != 0);
    cyc(hold);
    bus.ZOOM_IN_BTN  = 1'b0;
    bus.ZOOM_OUT_BTN = 1'b0;
    cyc(D + 8);
  endtask

  task automatic expect_cfg(input string name, input int lvl, input int dir, input int w, input int h);
    check({name, "_lvl"}, int'(bus.SHIFT_FACTOR),   lvl);
    check({name, "_dir"}, int'(bus.SCALE_DIR),      dir);
    check({name, "_w"},   int'(bus.IMG_WIDTH_OUT),  w);
    check({name, "_h"},   int'(bus.IMG_HEIGHT_OUT), h);
  endtask

  initial begin
    int n0;
    int exp_w[4];
    int exp_l[4];
    exp_w = '{320, 640, 1280, 1280};
    exp_l = '{1, 2, 3, 3};

    rst_n            = 1'b0;
    bus.ZOOM_IN_BTN  = 1'b0;
    bus.ZOOM_OUT_BTN = 1'b0;
    bus.ALGORITHM    = 2'b00;
    bus.ENGINE_IDLE  = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    expect_cfg("reset", 0, 0, 160, 120);
    check("reset_pending", int'(bus.CFG_PENDING), 0);
    check("reset_no_update", upd_cnt, 0);

    // Bounce shorter than the debounce window, then a clean hold
    n0 = upd_cnt;
    for (int i = 0; i < 10; i++) begin
      bus.ZOOM_IN_BTN = (i % 2 == 0);
      cyc(2);
    end
    bus.ZOOM_IN_BTN = 1'b1;
    cyc(D + 8);
    bus.ZOOM_IN_BTN = 1'b0;
    cyc(D + 8);
    check("bounce_updates", upd_cnt - n0, 1);
    expect_cfg("bounce", 1, 0, 320, 240);
    press(1, D + 8);
    expect_cfg("back_to_0", 0, 0, 160, 120);

    n0 = upd_cnt;
    for (int i = 0; i < 4; i++) begin
      press(0, D + 8);
      check("sweep_lvl", int'(bus.SHIFT_FACTOR), exp_l[i]);
      check("sweep_w",   int'(bus.IMG_WIDTH_OUT), exp_w[i]);
    end
    check("sweep_updates", upd_cnt - n0, 3);
    expect_cfg("sweep_top", 3, 0, 1280, 960);

    bus.ALGORITHM = 2'b10;
    cyc(8);
    expect_cfg("alg_dc", 1, 1, 80, 60);
    press(0, D + 8);
    expect_cfg("dc_lvl2", 2, 1, 40, 30);
    press(0, D + 8);
    expect_cfg("dc_sat", 2, 1, 40, 30);

    bus.ALGORITHM = 2'b01;
    cyc(8);
    expect_cfg("alg_pr", 1, 0, 320, 240);
    press(1, D + 8);
    expect_cfg("pr_lvl0", 0, 0, 160, 120);
    bus.ENGINE_IDLE = 1'b0;
    press(0, D + 8);
    press(0, D + 8);
    check("deferred_pending", int'(bus.CFG_PENDING), 1);
    expect_cfg("deferred_hold", 0, 0, 160, 120);
    n0 = upd_cnt;
    bus.ENGINE_IDLE = 1'b1;
    cyc(6);
    check("deferred_updates", upd_cnt - n0, 1);
    expect_cfg("deferred_commit", 2, 0, 640, 480);

    n0 = upd_cnt;
    press(2, D + 8);
    check("both_updates", upd_cnt - n0, 0);
    expect_cfg("both", 2, 0, 640, 480);

    bus.ENGINE_IDLE = 1'b0;
    press(0, D + 8);
    check("midreset_pending_before", int'(bus.CFG_PENDING), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #2;
    expect_cfg("midreset", 0, 0, 160, 120);
    check("midreset_pending", int'(bus.CFG_PENDING), 0);
    check("midreset_update", int'(bus.CFG_UPDATE), 0);
    bus.ALGORITHM = 2'b00;
    cyc(2);
    rst_n = 1'b1;
    bus.ENGINE_IDLE = 1'b1;
    cyc(5);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: press(0, $urandom_range(1, D + 8));
        1: press(1, $urandom_range(1, D + 8));
        2: press(2, $urandom_range(1, D + 8));
        3: bus.ALGORITHM = 2'($urandom_range(0, 3));
        4: bus.ENGINE_IDLE = 1'($urandom_range(0, 1));
        default: begin
          bus.ZOOM_IN_BTN = 1'($urandom_range(0, 1));
          cyc($urandom_range(1, D + 2));
          bus.ZOOM_IN_BTN = 1'b0;
        end
      endcase
      cyc($urandom_range(1, 15));
    end

    bus.ENGINE_IDLE = 1'b1;
    cyc(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
